// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
// The optional round-robin selection is enabled with the MEM_ARB_RR_EN macro.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam int unsigned BE_W_MAX = 64;
  localparam logic [BE_W_MAX-1:0] BE_ALL = '1;

endpackage

// File: rtl/arb_pick.sv
// Two-way chooser between fetch and data requests.
// MEM_ARB_RR_EN selects round-robin on ties; otherwise data has fixed priority.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic en,
  input  logic i_req,
  input  logic d_req,
  output logic gnt_i,
  output logic gnt_d
);

`ifdef MEM_ARB_RR_EN
  // Last served requester; resets to fetch so data wins the first tie.
  logic last;

  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (en) begin
      if (i_req && d_req) begin
        if (last == OWN_D) gnt_i = 1'b1;
        else               gnt_d = 1'b1;
      end else begin
        gnt_i = i_req;
        gnt_d = d_req;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)        last <= OWN_I;
    else if (gnt_d) last <= OWN_D;
    else if (gnt_i) last <= OWN_I;
  end
`else
  logic unused_rr;

  assign gnt_d     = en & d_req;
  assign gnt_i     = en & i_req & ~d_req;
  assign unused_rr = ^{CLK, RST};
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data accesses onto one single-port memory with timeout.
// Build with MEM_ARB_RR_EN for round-robin tie-breaking (see arb_pick).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_W/8-1:0]   d_be,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     rdata,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ready,
  output logic                  err
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t              state;
  logic                owner;
  logic                we_r;
  logic                err_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [BE_W-1:0]     be_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [CNT_W-1:0]    cnt;
  logic                idle;
  logic                access;
  logic                resp;
  logic                timed_out;

  assign idle   = (state == IDLE);
  assign access = (state == ACCESS);
  assign resp   = (state == RESP);

  arb_pick u_pick (
    .CLK   (CLK),
    .RST   (RST),
    .en    (idle),
    .i_req (i_req),
    .d_req (d_req),
    .gnt_i (i_gnt),
    .gnt_d (d_gnt)
  );

  assign timed_out = (TIMEOUT != 0) && !mem_ready && (cnt == CNT_W'(TIMEOUT - 1));

  assign mem_cs    = access;
  assign mem_we    = access & we_r;
  assign mem_be    = access ? be_r    : '0;
  assign mem_addr  = access ? addr_r  : '0;
  assign mem_wdata = access ? wdata_r : '0;

  assign i_rvalid  = resp & (owner == OWN_I);
  assign d_rvalid  = resp & (owner == OWN_D);
  assign err       = resp & err_r;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      owner   <= OWN_D;
      we_r    <= 1'b0;
      err_r   <= 1'b0;
      addr_r  <= '0;
      be_r    <= '0;
      wdata_r <= '0;
      cnt     <= '0;
      rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_gnt || d_gnt) begin
            state <= ACCESS;
            cnt   <= '0;
            err_r <= 1'b0;
            if (d_gnt) begin
              owner   <= OWN_D;
              addr_r  <= d_addr;
              we_r    <= d_we;
              be_r    <= d_be;
              wdata_r <= d_wdata;
            end else begin
              owner   <= OWN_I;
              addr_r  <= i_addr;
              we_r    <= 1'b0;
              be_r    <= BE_ALL[BE_W-1:0];
              wdata_r <= '0;
            end
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            rdata <= mem_rdata;
            state <= RESP;
          end else if (timed_out) begin
            rdata <= '0;
            err_r <= 1'b1;
            state <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port instruction/data memory between the multi-cycle CPU's two requesters: instruction fetch (state 0 path) and data load/store (LW/SW MEM states). Sits between the Control-sequenced datapath and the memory. Serialises accesses, tolerates variable memory latency via mem_ready, and aborts hung accesses with a timeout error.

Parameters:
ADDR_W, 32, address width.
DATA_W, 32, data width. BE width is DATA_W/8.
TIMEOUT, 15, max ACCESS cycles waiting for mem_ready; 0 disables the timeout.

Ports:
CLK  in  1  clock, rising edge.
RST  in  1  asynchronous, active-high reset.
i_req  in  1  fetch request, level, held until i_gnt.
i_addr  in  ADDR_W  fetch address.
i_gnt  out  1  fetch grant pulse.
i_rvalid  out  1  fetch data valid pulse.
d_req  in  1  data request, level, held until d_gnt.
d_we  in  1  1 = store, 0 = load.
d_be  in  DATA_W/8  byte enables.
d_addr  in  ADDR_W  data address.
d_wdata  in  DATA_W  store data.
d_gnt  out  1  data grant pulse.
d_rvalid  out  1  load data / store ack pulse.
rdata  out  DATA_W  read data to both requesters; qualified by i_rvalid/d_rvalid.
mem_cs  out  1  memory select.
mem_we  out  1  memory write.
mem_be  out  DATA_W/8  memory byte enables.
mem_addr  out  ADDR_W  memory address.
mem_wdata  out  DATA_W  memory write data.
mem_rdata  in  DATA_W  memory read data, valid with mem_ready.
mem_ready  in  1  memory completion.
err  out  1  timeout pulse, coincident with rvalid.

Behaviour:
- Reset, async: state IDLE; all outputs 0; rdata 0; timeout counter 0; owner and round-robin pointer favour data.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any req is high, the grant is combinational from req in the same cycle. Selection: data wins when both are high. With the optional feature, the requester not served last wins.
- On the grant edge, register owner, addr, we, be and wdata; go to ACCESS. Fetch always uses be = all ones and we = 0.
- ACCESS: mem_cs = 1 and mem_* are driven from the registers, stable until exit. If mem_ready = 1, capture mem_rdata into rdata and go to RESP. Otherwise increment the counter.
- Timeout: if TIMEOUT > 0, mem_ready = 0 and counter == TIMEOUT-1, go to RESP with rdata = 0 and err = 1 in RESP.
- RESP: exactly one of i_rvalid/d_rvalid = 1, per owner. A store also pulses d_rvalid as its ack. Clear the counter; go to IDLE.
- Minimum latency: req at cycle n, gnt at n, ACCESS at n+1 (mem_ready = 1), rvalid at n+2. Peak throughput is one access per 3 cycles.
- Requests are sampled only in IDLE. A req dropped before grant has no effect. The loser keeps waiting through ACCESS and RESP.
- mem_cs, mem_we and all gnt/rvalid/err are 0 outside their stated states. rdata holds its last value.
- RST mid-ACCESS: mem_cs drops immediately; the transaction is discarded with no rvalid or err.

Optional Feature:
MEM_ARB_RR_EN.
- Defined: round-robin on simultaneous requests, with a pointer updated at each grant.
- Undefined: fixed data-over-fetch priority; the pointer logic is absent.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, ACCESS, RESP};
  - owner encoding OWN_I = 0, OWN_D = 1;
  - the BE_ALL constant.
- Sub-module arb_pick: 2-way chooser (req pair + last owner -> one-hot grant). It is the only place the macro is referenced.

Test Plan:
- i_req = 1, i_addr = 0x100, mem_ready = 1 in the first ACCESS cycle -> i_gnt at cycle 0, mem_cs/mem_addr = 0x100/mem_be = 0xF at cycle 1, i_rvalid with rdata = mem_rdata at cycle 2, err = 0.
- d_req store, d_addr = 0x2004, d_be = 0x3, d_wdata = 0xBEEF, mem_ready delayed 3 cycles -> mem_we = 1 and stable for 4 ACCESS cycles, then d_rvalid pulse.
- i_req and d_req together, twice back-to-back -> without the macro, D then D. With MEM_ARB_RR_EN, D then I. Never two grants in one cycle.
- mem_ready held 0, TIMEOUT = 15 -> 15 ACCESS cycles, then RESP with rdata = 0, err = 1, owner rvalid = 1, then IDLE.
- RST asserted during ACCESS -> mem_cs = 0 asynchronously, no rvalid. After release, a new i_req completes normally.
